gpdout: RTL and testbench
=========================

Name: gpdout

Overview:
- General-purpose data output port. It is the transmit-side counterpart of the general-purpose input register.
- The CPU writes a 32-bit output word over a simple single-cycle register bus. Writes support byte strobes and atomic SET/CLR/TGL aliases.
- A timed PULSE register forces selected bits high for a fixed number of cycles and then self-clears.
- Data is held internally little-endian and byte-reversed onto the edge pins, so the pins carry big-endian order, matching the input port.

Parameters:
- PULSE_CYCLES, 16, number of clock cycles a pulse bit is held high (legal range 1..65535).
- CNT_W, 16, width of the pulse down-counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; reset=0 resets.
- en  input  1  write strobe; one register write per cycle when high.
- addr  input  3  word index of the register being accessed.
- wdata  input  32  write data, little-endian (byte 0 = wdata[7:0]).
- wstrb  input  4  byte-lane enables; wstrb[i] qualifies wdata[8i+7:8i].
- rdata  output  32  combinational readback of the register selected by addr.
- doutToEdge  output  32  registered pin output, big-endian byte order.
- pulse_busy  output  1  high while the pulse counter is nonzero.

Behaviour:
- Registers: data[31:0], pulse_mask[31:0], cnt[CNT_W-1:0], doutToEdge[31:0]. All are flops.
- Reset (reset=0 at an edge): data, pulse_mask, cnt and doutToEdge all = 0; pulse_busy = 0. Reset overrides any simultaneous write or count.
- Write decode (en=1). Per byte lane i with wstrb[i]=1:
  - addr 0 DATA: data byte i = wdata byte i.
  - addr 1 SET: data byte i |= wdata byte i.
  - addr 2 CLR: data byte i &= ~wdata byte i.
  - addr 3 TGL: data byte i ^= wdata byte i.
  - addr 4 PULSE: pulse_mask byte i |= wdata byte i, and cnt reloads to PULSE_CYCLES. Reload happens if any wstrb bit is set, even if all strobed wdata bytes are zero.
  - addr 5..7: writes ignored.
  - Lanes with wstrb[i]=0 are unchanged. A write with wstrb=0 has no effect, including no counter reload.
- Pulse counter:
  - States: IDLE (cnt==0) and ACTIVE (cnt!=0). pulse_busy = (cnt!=0).
  - In ACTIVE with no PULSE write, cnt decrements by 1 each cycle.
  - On the edge where cnt goes 1->0, pulse_mask clears to 0 in the same edge. Result: pulse bits are visible for exactly PULSE_CYCLES cycles after the write edge.
  - A PULSE write while ACTIVE (retrigger): the new mask is ORed in and cnt reloads to PULSE_CYCLES. Reload wins over decrement, and old bits stay high through the extended window.
  - A DATA/SET/CLR/TGL write during ACTIVE does not affect cnt or pulse_mask.
- Output:
  - out_le = data_next | pulse_mask_next.
  - doutToEdge[31:24]=out_le[7:0]; [23:16]=out_le[15:8]; [15:8]=out_le[23:16]; [7:0]=out_le[31:24].
  - doutToEdge updates on the same edge that commits a write or counter expiry (zero extra latency). There is no combinational path from inputs to doutToEdge.
- Readback (combinational, no side effects):
  - addr 0..3: data.
  - addr 4: pulse_mask.
  - addr 5: {cnt zero-extended/truncated to 16 bits in [31:16], 15'b0, pulse_busy}.
  - addr 6..7: 0.
  - rdata reflects register values before the current edge; no read-during-write forwarding.
- A reset asserted mid-pulse aborts the pulse immediately: the pins go to 0 at that edge.

Decomposition:
- Shared package gpio_pkg: register index constants GPD_DATA=0, GPD_SET=1, GPD_CLR=2, GPD_TGL=3, GPD_PULSE=4, GPD_STATUS=5, plus a byte-swap function shared with the input port.
- One natural sub-module, gpdout_pulse_timer: cnt, reload/decrement logic and the busy flag. It takes a load strobe and outputs busy plus an expire strobe.

Test Plan:
- Reset: hold reset=0 for 3 cycles with en=1, addr=0, wdata=0xFFFFFFFF -> doutToEdge=0, rdata(addr 0)=0, pulse_busy=0.
- Full and partial writes:
  - DATA write 0x11223344, wstrb=0xF -> next cycle doutToEdge=0x44332211, rdata(0)=0x11223344.
  - Then DATA 0xAABBCCDD, wstrb=0x2 -> data=0x1122CC44, doutToEdge=0x44CC2211.
- Atomic aliases, starting from data=0x0000FF00:
  - SET 0x000000F0 -> 0x0000FFF0.
  - CLR 0x00000F00 -> 0x0000F0F0.
  - TGL 0xFFFFFFFF with wstrb=0x1 -> 0x0000F00F.
- Pulse with PULSE_CYCLES=4, data=0: PULSE write 0x00000001 -> doutToEdge=0x01000000 for exactly 4 cycles, then 0. pulse_busy high for those 4 cycles. STATUS reads cnt 4,3,2,1, then 0.
- Retrigger with PULSE_CYCLES=4: write mask 0x1, then 2 cycles later write 0x2 -> out_le=0x3 for 4 further cycles (6 total for bit 0), then 0. A concurrent DATA write of 0x100 during the pulse leaves 0x100 set after expiry.
- Reset mid-pulse: reset=0 on cycle 2 of an active pulse -> doutToEdge=0, cnt=0 and pulse_mask=0 at that edge. No residual pulse after reset is released.

Source files
------------

// File: rtl/gpio_pkg.sv
// Definitions shared by the general-purpose input and output ports:
// register word indices and byte-lane helpers.
package gpio_pkg;

    localparam logic [2:0] GPD_DATA   = 3'd0;
    localparam logic [2:0] GPD_SET    = 3'd1;
    localparam logic [2:0] GPD_CLR    = 3'd2;
    localparam logic [2:0] GPD_TGL    = 3'd3;
    localparam logic [2:0] GPD_PULSE  = 3'd4;
    localparam logic [2:0] GPD_STATUS = 3'd5;

    // Reverse byte order of a 32-bit word (little-endian <-> pin order).
    function automatic logic [31:0] gp_byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Expand four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] gp_strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/gpdout_pulse_timer.sv
// Down-counter that defines the pulse window: a load reloads it, it then
// counts to zero and flags the edge on which the window closes.
module gpdout_pulse_timer
    import gpio_pkg::*;
#(
    parameter int PULSE_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    output logic             busy_o,
    output logic             expire_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a reload beats the decrement, idle holds at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o   = (cnt_q != CNT_ZERO);
    assign expire_o = (!load_i) && (cnt_q == CNT_ONE);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/gpdout.sv
// General-purpose output port: byte-strobed data register with SET/CLR/TGL
// aliases and a self-clearing pulse mask, driven big-endian onto the pins.
module gpdout
    import gpio_pkg::*;
#(
    parameter int PULSE_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic [31:0] doutToEdge,
    output logic        pulse_busy
);

    localparam int CW16 = (CNT_W < 16) ? CNT_W : 16;

    logic [31:0]      data_q;
    logic [31:0]      data_d;
    logic [31:0]      pulse_mask_q;
    logic [31:0]      pulse_mask_d;
    logic [31:0]      dout_q;
    logic [31:0]      dout_d;
    logic [31:0]      lane_mask_s;
    logic [31:0]      wbits_s;
    logic             pulse_load_s;
    logic             expire_s;
    logic [CNT_W-1:0] cnt_s;
    logic [15:0]      cnt16_s;

    assign lane_mask_s  = gp_strb_mask(wstrb);
    assign wbits_s      = wdata & lane_mask_s;
    // An all-zero strobe is a no-op, so it must not restart the pulse window.
    assign pulse_load_s = en && (addr == GPD_PULSE) && (wstrb != 4'b0000);

    gpdout_pulse_timer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pulse_load_s),
        .busy_o   (pulse_busy),
        .expire_o (expire_s),
        .cnt_o    (cnt_s)
    );

    // Data register write decode; unstrobed lanes keep their value.
    always_comb begin
        data_d = data_q;
        if (en) begin
            case (addr)
                GPD_DATA: data_d = (data_q & ~lane_mask_s) | wbits_s;
                GPD_SET:  data_d = data_q | wbits_s;
                GPD_CLR:  data_d = data_q & ~wbits_s;
                GPD_TGL:  data_d = data_q ^ wbits_s;
                default:  data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Pulse mask accumulates on load and drops on the expiry edge.
    always_comb begin
        pulse_mask_d = pulse_mask_q;
        if (pulse_load_s) begin
            pulse_mask_d = pulse_mask_q | wbits_s;
        end else if (expire_s) begin
            pulse_mask_d = 32'h0000_0000;
        end else begin
            pulse_mask_d = pulse_mask_q;
        end
    end

    // Pins follow the next-state values so they move on the committing edge.
    always_comb begin
        dout_d = gp_byte_swap(data_d | pulse_mask_d);
    end

    // Port state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q       <= 32'h0000_0000;
            pulse_mask_q <= 32'h0000_0000;
            dout_q       <= 32'h0000_0000;
        end else begin
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            dout_q       <= dout_d;
        end
    end

    assign doutToEdge = dout_q;
    assign cnt16_s    = 16'(cnt_s[CW16-1:0]);

    // Register readback from current state only.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            GPD_DATA, GPD_SET, GPD_CLR, GPD_TGL: rdata = data_q;
            GPD_PULSE:  rdata = pulse_mask_q;
            GPD_STATUS: rdata = {cnt16_s, 15'b000_0000_0000_0000, pulse_busy};
            default:    rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_gpdout.sv
// Directed and randomized bench for gpdout against a cycle-indexed model.
module tb_gpdout;

    localparam int PC = 4;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [31:0] doutToEdge;
    logic        pulse_busy;

    int          checks;
    int          errors;
    int          cyc;
    int          pulse_end;
    logic [31:0] m_data;
    logic [31:0] m_mask;
    logic        model_ok;
    logic [31:0] v;

    gpdout #(.PULSE_CYCLES(PC), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .addr       (addr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rdata      (rdata),
        .doutToEdge (doutToEdge),
        .pulse_busy (pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int remaining();
        return (pulse_end > cyc) ? (pulse_end - cyc) : 0;
    endfunction

    function automatic logic [31:0] pins(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] a);
        int rem;
        rem = remaining();
        if (a <= 3'd3) return m_data;
        if (a == 3'd4) return m_mask;
        if (a == 3'd5) return {16'(rem), 15'd0, (rem > 0)};
        return 32'h0;
    endfunction

    task automatic model_edge(input logic rst, input logic e, input logic [2:0] a,
                              input logic [31:0] wd, input logic [3:0] ws);
        logic [7:0] b;
        logic [7:0] w;
        cyc++;
        if (!rst) begin
            m_data    = 32'h0;
            m_mask    = 32'h0;
            pulse_end = cyc;
        end else begin
            if (e && ws != 4'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (ws[i]) begin
                        b = m_data[8*i +: 8];
                        w = wd[8*i +: 8];
                        case (a)
                            3'd0: b = w;
                            3'd1: b = b | w;
                            3'd2: b = b & ~w;
                            3'd3: b = b ^ w;
                            3'd4: m_mask[8*i +: 8] = m_mask[8*i +: 8] | w;
                            default: ;
                        endcase
                        m_data[8*i +: 8] = b;
                    end
                end
                if (a == 3'd4) pulse_end = cyc + PC;
            end
            if (pulse_end <= cyc) m_mask = 32'h0;
        end
    endtask

    task automatic do_cycle(input logic rst, input logic e, input logic [2:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        reset = rst; en = e; addr = a; wdata = wd; wstrb = ws;
        #1;
        if (model_ok) check("rdata", rdata, model_rdata(a));
        @(posedge clk);
        #1;
        model_edge(rst, e, a, wd, ws);
        model_ok = 1'b1;
        check("dout", doutToEdge, pins(m_data | m_mask));
        check("busy", {31'd0, pulse_busy}, {31'd0, (remaining() > 0)});
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] val);
        en = 1'b0; addr = a;
        #1;
        val = rdata;
    endtask

    initial begin
        clk = 1'b0; checks = 0; errors = 0; cyc = 0; pulse_end = 0;
        m_data = 32'h0; m_mask = 32'h0; model_ok = 1'b0;

        repeat (3) do_cycle(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF);
        check("rst_dout", doutToEdge, 32'h0);
        check("rst_busy", {31'd0, pulse_busy}, 32'h0);
        peek(3'd0, v); check("rst_rd0", v, 32'h0);

        do_cycle(1'b1, 1'b1, 3'd0, 32'h1122_3344, 4'hF);
        check("full_dout", doutToEdge, 32'h4433_2211);
        peek(3'd0, v); check("full_rd", v, 32'h1122_3344);
        do_cycle(1'b1, 1'b1, 3'd0, 32'hAABB_CCDD, 4'h2);
        check("part_dout", doutToEdge, 32'h44CC_2211);
        peek(3'd0, v); check("part_rd", v, 32'h1122_CC44);

        do_cycle(1'b1, 1'b1, 3'd0, 32'h0000_FF00, 4'hF);
        do_cycle(1'b1, 1'b1, 3'd1, 32'h0000_00F0, 4'hF);
        peek(3'd0, v); check("set", v, 32'h0000_FFF0);
        do_cycle(1'b1, 1'b1, 3'd2, 32'h0000_0F00, 4'hF);
        peek(3'd0, v); check("clr", v, 32'h0000_F0F0);
        do_cycle(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'h1);
        peek(3'd0, v); check("tgl", v, 32'h0000_F00F);

        // single pulse: visible for PC cycles, STATUS counts PC..1 then 0
        do_cycle(1'b1, 1'b1, 3'd0, 32'h0, 4'hF);
        do_cycle(1'b1, 1'b1, 3'd4, 32'h0000_0001, 4'hF);
        for (int k = 0; k <= PC; k++) begin
            peek(3'd5, v);
            check("pulse_cnt", {16'd0, v[31:16]}, 32'(PC - k));
            check("pulse_pin", doutToEdge, (k < PC) ? 32'h0100_0000 : 32'h0);
            check("pulse_bsy", {31'd0, pulse_busy}, (k < PC) ? 32'd1 : 32'd0);
            do_cycle(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        end

        // zero-strobe pulse write must not start a window
        do_cycle(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'h0);
        check("nostrb_bsy", {31'd0, pulse_busy}, 32'h0);

        // retrigger with an interleaved data write
        do_cycle(1'b1, 1'b1, 3'd4, 32'h0000_0001, 4'hF);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b1, 3'd4, 32'h0000_0002, 4'hF);
        check("retrig", doutToEdge, 32'h0300_0000);
        do_cycle(1'b1, 1'b1, 3'd0, 32'h0000_0100, 4'hF);
        check("retrig_data", doutToEdge, 32'h0301_0000);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        check("retrig_hold", doutToEdge, 32'h0301_0000);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        check("retrig_end", doutToEdge, 32'h0001_0000);

        // reset mid-pulse, with a colliding pulse write
        do_cycle(1'b1, 1'b1, 3'd0, 32'h0, 4'hF);
        do_cycle(1'b1, 1'b1, 3'd4, 32'h0000_0080, 4'hF);
        do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        do_cycle(1'b0, 1'b1, 3'd4, 32'h0000_00FF, 4'hF);
        check("mid_rst_pin", doutToEdge, 32'h0);
        reset = 1'b1;
        peek(3'd5, v); check("mid_rst_cnt", v, 32'h0);
        peek(3'd4, v); check("mid_rst_mask", v, 32'h0);
        repeat (5) do_cycle(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        check("post_rst_pin", doutToEdge, 32'h0);

        for (int n = 0; n < 400; n++) begin
            do_cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                     3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
